pattern_serial_tx: RTL and testbench

//  Serial pattern transmitter: accepts a DATA_W-bit word over a valid/ready load port and shifts it
//  out MSB-first on one registered bit line, repeating the frame back-to-back a programmable number of times.

---
 rtl/seq_pkg.sv | 20 ++
 rtl/pattern_serial_tx_bit_counter.sv | 48 ++++
 rtl/pattern_serial_tx.sv | 200 ++++++++++++++++++++
 tb/tb_pattern_serial_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the sequence
// detectors it drives.
//   ST_IDLE / ST_SHIFT / ST_PAR : state encodings
//   tx_state_e                  : FSM state type built on those encodings
//   PAT_1011                    : common detector/stimulus pattern
package seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAR   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_PAR   = ST_PAR
  } tx_state_e;

  localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/pattern_serial_tx_bit_counter.sv
// tx_bit_counter: loadable down-counter with zero flag.
// The next-state value is exported so the owner can register outputs that
// depend on the value the counter is about to take.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       load load_val (priority over dec)
//   load_val   value to load
//   dec        decrement by one (saturates at zero)
//   count_nxt  value the counter takes at the next edge
//   zero       current count is zero
module tx_bit_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count_nxt,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Next count: load wins over decrement, decrement stops at zero
  always_comb begin
    count_nxt = count_r;
    if (load) begin
      count_nxt = load_val;
    end else if (dec && (count_r != '0)) begin
      count_nxt = count_r - W'(1'b1);
    end else begin
      count_nxt = count_r;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else begin
      count_r <= count_nxt;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/pattern_serial_tx.sv
// pattern_serial_tx: accepts a DATA_W-bit word over a valid/ready port and
// shifts it out MSB-first on a registered bit line, sending the frame
// load_repeat+1 times back-to-back.
// Build option: define SEQ_TX_PARITY_EN to append an even-parity bit to
// every frame (frame_done/all_done then pulse on the parity bit).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load_valid   load request
//   load_ready   load can be accepted (combinational)
//   load_data    frame pattern, MSB first
//   load_repeat  extra repetitions (0 = one frame)
//   abort        synchronous abort
//   dout         serial bit (registered)
//   dout_valid   dout carries a frame bit (registered)
//   busy         transmission in progress
//   frame_done   pulse with the last bit of each frame
//   all_done     pulse with the last bit of the last frame
module pattern_serial_tx
  import seq_pkg::*;
#(
  parameter int   DATA_W   = 4,
  parameter int   REPEAT_W = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [DATA_W-1:0]   load_data,
  input  logic [REPEAT_W-1:0] load_repeat,
  input  logic                abort,
  output logic                dout,
  output logic                dout_valid,
  output logic                busy,
  output logic                frame_done,
  output logic                all_done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

`ifdef SEQ_TX_PARITY_EN
  // Even-parity bit of a frame word
  function automatic logic even_parity(input logic [DATA_W-1:0] v);
    return ^v;
  endfunction
`endif

  tx_state_e           state_r;
  tx_state_e           state_s;
  logic [DATA_W-1:0]   shadow_r;
  logic [DATA_W-1:0]   shadow_s;
  logic                accept_s;
  logic                cnt_load_s;
  logic                cnt_dec_s;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                cnt_zero_s;
  logic                rep_load_s;
  logic                rep_dec_s;
  logic [REPEAT_W-1:0] rep_nxt_s;
  logic                rep_zero_s;
  logic                dout_s;
  logic                dout_valid_s;
  logic                frame_done_s;
  logic                all_done_s;

  assign load_ready = (state_r == S_IDLE) && !abort && !rst;
  assign accept_s   = load_valid && load_ready;
  assign busy       = (state_r != S_IDLE);

  // Bit position within the frame
  tx_bit_counter #(.W(CNT_W)) u_bit_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load_s),
    .load_val  (CNT_TOP),
    .dec       (cnt_dec_s),
    .count_nxt (cnt_nxt_s),
    .zero      (cnt_zero_s)
  );

  // Frames still to send after the current one
  tx_bit_counter #(.W(REPEAT_W)) u_rep_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (rep_load_s),
    .load_val  (load_repeat),
    .dec       (rep_dec_s),
    .count_nxt (rep_nxt_s),
    .zero      (rep_zero_s)
  );

  // Next-state logic and counter control
  always_comb begin
    state_s    = state_r;
    shadow_s   = shadow_r;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    rep_load_s = 1'b0;
    rep_dec_s  = 1'b0;
    if (abort) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            state_s    = S_SHIFT;
            shadow_s   = load_data;
            cnt_load_s = 1'b1;
            rep_load_s = 1'b1;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_SHIFT: begin
          if (!cnt_zero_s) begin
            cnt_dec_s = 1'b1;
          end else begin
`ifdef SEQ_TX_PARITY_EN
            state_s = S_PAR;
`else
            // Next frame starts on the very next cycle, no gap bit
            if (!rep_zero_s) begin
              rep_dec_s  = 1'b1;
              cnt_load_s = 1'b1;
            end else begin
              state_s = S_IDLE;
            end
`endif
          end
        end
`ifdef SEQ_TX_PARITY_EN
        S_PAR: begin
          if (!rep_zero_s) begin
            rep_dec_s  = 1'b1;
            cnt_load_s = 1'b1;
            state_s    = S_SHIFT;
          end else begin
            state_s = S_IDLE;
          end
        end
`endif
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // Output values for the cycle that follows the next edge, so that the
  // bit line and pulses come straight from flops
  always_comb begin
    dout_s       = IDLE_BIT;
    dout_valid_s = 1'b0;
    frame_done_s = 1'b0;
    all_done_s   = 1'b0;
    case (state_s)
      S_SHIFT: begin
        dout_s       = shadow_s[cnt_nxt_s];
        dout_valid_s = 1'b1;
`ifndef SEQ_TX_PARITY_EN
        frame_done_s = (cnt_nxt_s == '0);
        all_done_s   = (cnt_nxt_s == '0) && (rep_nxt_s == '0);
`endif
      end
`ifdef SEQ_TX_PARITY_EN
      S_PAR: begin
        dout_s       = even_parity(shadow_s);
        dout_valid_s = 1'b1;
        frame_done_s = 1'b1;
        all_done_s   = (rep_nxt_s == '0);
      end
`endif
      default: begin
        dout_s       = IDLE_BIT;
        dout_valid_s = 1'b0;
      end
    endcase
  end

  // State, shadow word and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      shadow_r   <= '0;
      dout       <= IDLE_BIT;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      all_done   <= 1'b0;
    end else begin
      state_r    <= state_s;
      shadow_r   <= shadow_s;
      dout       <= dout_s;
      dout_valid <= dout_valid_s;
      frame_done <= frame_done_s;
      all_done   <= all_done_s;
    end
  end

endmodule

// File: tb/tb_pattern_serial_tx.sv
// Directed bench for pattern_serial_tx. Cycle k means k edges after the
// accepting edge; everything is sampled 1 time unit after a rising edge.
module tb_pattern_serial_tx;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_data;
  logic [3:0] load_repeat;
  logic       abort;
  logic       dout;
  logic       dout_valid;
  logic       busy;
  logic       frame_done;
  logic       all_done;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] bits;
  logic [63:0] fd;
  logic [63:0] ad;
  int          nv;

  always #5 clk = ~clk;

  pattern_serial_tx #(.DATA_W(4), .REPEAT_W(4), .IDLE_BIT(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_repeat (load_repeat),
    .abort       (abort),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .frame_done  (frame_done),
    .all_done    (all_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [3:0] d, input logic [3:0] r);
    load_data   = d;
    load_repeat = r;
    load_valid  = 1'b1;
    #1;
    check("ready_at_load", 64'(load_ready), 64'd1);
    tick();
    load_valid = 1'b0;
  endtask

  // Record n cycles of the serial line, oldest bit ends up most significant
  task automatic collect(input int n, output logic [63:0] b, output logic [63:0] f,
                         output logic [63:0] a, output int v);
    b = 64'd0;
    f = 64'd0;
    a = 64'd0;
    v = 0;
    for (int i = 0; i < n; i++) begin
      b = {b[62:0], dout};
      f = {f[62:0], frame_done};
      a = {a[62:0], all_done};
      if (dout_valid) v++;
      tick();
    end
  endtask

  // Overlapping 1011 detector over the first n recorded bits
  function automatic int count_1011(input logic [63:0] s, input int n);
    int c = 0;
    for (int i = 0; i <= n - 4; i++) begin
      if (s[i +: 4] == PAT_1011) c++;
    end
    return c;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(dout_valid), 64'd0);
    check({tag, "_dout"},  64'(dout),       64'd0);
    check({tag, "_busy"},  64'(busy),       64'd0);
  endtask

  initial begin
    rst         = 1'b1;
    load_valid  = 1'b0;
    load_data   = 4'd0;
    load_repeat = 4'd0;
    abort       = 1'b0;
    tick();
    tick();
    check_idle("reset");
    check("reset_fd",    64'(frame_done), 64'd0);
    check("reset_ad",    64'(all_done),   64'd0);
    check("reset_ready", 64'(load_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post_reset_ready", 64'(load_ready), 64'd1);
    tick();

`ifndef SEQ_TX_PARITY_EN
    // single frame
    load_word(4'b1011, 4'd0);
    collect(4, bits, fd, ad, nv);
    check("t1_bits", bits, 64'hB);
    check("t1_fd",   fd,   64'h1);
    check("t1_ad",   ad,   64'h1);
    check("t1_nv",   64'(nv), 64'd4);
    check_idle("t1_after");
    check("t1_ready", 64'(load_ready), 64'd1);

    // three back-to-back frames
    load_word(4'b1011, 4'd2);
    collect(12, bits, fd, ad, nv);
    check("t2_bits", bits, 64'hBBB);
    check("t2_fd",   fd,   64'h111);
    check("t2_ad",   ad,   64'h001);
    check("t2_nv",   64'(nv), 64'd12);
    check("t2_det",  64'(count_1011(bits, 12)), 64'd3);
    check_idle("t2_after");

    // load_valid held during transmission is ignored
    load_word(4'b0110, 4'd0);
    load_data  = 4'b1111;
    load_valid = 1'b1;
    collect(4, bits, fd, ad, nv);
    check("t3_bits", bits, 64'h6);
    check("t3_fd",   fd,   64'h1);
    check("t3_gap_valid", 64'(dout_valid), 64'd0);
    check("t3_gap_ready", 64'(load_ready), 64'd1);
    tick();
    load_valid = 1'b0;
    collect(4, bits, fd, ad, nv);
    check("t3_bits2", bits, 64'hF);
    check("t3_nv2",   64'(nv), 64'd4);

    // abort in the middle of a frame
    load_word(4'b1011, 4'd0);
    tick();
    check("t4_bit2", 64'(dout), 64'd0);
    check("t4_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    tick();
    check_idle("t4_abort");
    abort = 1'b0;
    collect(4, bits, fd, ad, nv);
    check("t4_fd", fd, 64'h0);
    check("t4_ad", ad, 64'h0);
    check("t4_nv", 64'(nv), 64'd0);
    // abort and load together in idle: nothing accepted
    abort      = 1'b1;
    load_valid = 1'b1;
    load_data  = 4'b1011;
    #1;
    check("t4_ready_abort", 64'(load_ready), 64'd0);
    tick();
    abort      = 1'b0;
    load_valid = 1'b0;
    check("t4_no_accept_busy", 64'(busy), 64'd0);
    collect(3, bits, fd, ad, nv);
    check("t4_no_accept_nv", 64'(nv), 64'd0);

    // asynchronous reset mid-frame
    load_word(4'b1011, 4'd0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_idle("t5_rst");
    check("t5_rst_fd",    64'(frame_done), 64'd0);
    check("t5_rst_ready", 64'(load_ready), 64'd0);
    rst = 1'b0;
    tick();
    load_word(4'b1011, 4'd0);
    collect(4, bits, fd, ad, nv);
    check("t5_bits", bits, 64'hB);
    check("t5_fd",   fd,   64'h1);

    // maximum repeat count: 16 frames
    load_word(4'b1011, 4'hF);
    collect(64, bits, fd, ad, nv);
    check("t7_bits", bits, 64'hBBBB_BBBB_BBBB_BBBB);
    check("t7_fd",   fd,   64'h1111_1111_1111_1111);
    check("t7_ad",   ad,   64'h1);
    check("t7_nv",   64'(nv), 64'd64);
    check_idle("t7_after");
`else
    // parity bit appended to every frame
    load_word(4'b1011, 4'd0);
    collect(5, bits, fd, ad, nv);
    check("t6_bits", bits, 64'h17);
    check("t6_fd",   fd,   64'h1);
    check("t6_ad",   ad,   64'h1);
    check("t6_nv",   64'(nv), 64'd5);
    check_idle("t6_after");

    load_word(4'b1001, 4'd0);
    collect(5, bits, fd, ad, nv);
    check("t6_bits0", bits, 64'h12);
    check("t6_nv0",   64'(nv), 64'd5);

    load_word(4'b1011, 4'd1);
    collect(10, bits, fd, ad, nv);
    check("t6_rep_bits", bits, 64'h2F7);
    check("t6_rep_fd",   fd,   64'h21);
    check("t6_rep_ad",   ad,   64'h1);
    check_idle("t6_rep_after");

    load_word(4'b1011, 4'd0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("t6_abort");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
